uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart.sv | 178 +++++++++++++++++
 tb/tb_uart.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// uart: memory-mapped 8N1 UART with programmable clocks-per-bit, status flags and optional interrupt.
// Ports: clk; reset (async, active-low); cs/wen/addr/din register bus with combinational dout;
// RxD serial input (idle high, asynchronous); TxD serial output (idle high); irq interrupt request.
// Registers: 0 DR, 1 CTRL, 2 STAT, 3 CPB; addresses 4..15 read 0.
// Build option: define UART_IRQ_EN to enable irq and CTRL bits 2-3 (RX_IE, TX_IE).
module uart #(
  parameter int          SIM_PRINT   = 0,
  parameter logic [15:0] DEFAULT_CPB = 16'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wen,
  input  logic [3:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        RxD,
  output logic        TxD,
  output logic        irq
);
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] cpb_q, cpb_d;
  logic        rxfull_q, rxfull_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        tx_busy_q, tx_busy_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_cpb_q, tx_cpb_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [2:0]  rx_sync_q, rx_sync_d;
  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_cpb_q, rx_cpb_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        bus_wr, bus_rd, wr_dr, wr_ctrl, wr_stat, wr_cpb, rd_dr;
  logic [15:0] cpb_eff, rx_half;
  logic        tx_load, tx_tick, rx_in, rx_fall, rx_tick, rx_done, rx_store;
  logic [3:0]  ctrl_wdata;
  // upper write-data bits and SIM_PRINT have no hardware function
  logic        unused_bits;
  assign unused_bits = ^{din[31:16], SIM_PRINT != 0};
  assign bus_wr  = cs & wen;
  assign bus_rd  = cs & ~wen;
  assign wr_dr   = bus_wr & (addr == 4'd0);
  assign wr_ctrl = bus_wr & (addr == 4'd1);
  assign wr_stat = bus_wr & (addr == 4'd2);
  assign wr_cpb  = bus_wr & (addr == 4'd3);
  assign rd_dr   = bus_rd & (addr == 4'd0);
  assign cpb_eff = (cpb_q < 16'd4) ? 16'd4 : cpb_q;
`ifdef UART_IRQ_EN
  assign ctrl_wdata = din[3:0];
`else
  assign ctrl_wdata = {2'b00, din[1:0]};
`endif
  assign dout = !bus_rd          ? 32'd0 :
                (addr == 4'd0)   ? {24'd0, rx_data_q} :
                (addr == 4'd1)   ? {28'd0, ctrl_q} :
                (addr == 4'd2)   ? {28'd0, ferr_q, overrun_q, tx_busy_q, rxfull_q} :
                (addr == 4'd3)   ? {16'd0, cpb_q} : 32'd0;
  // the shifter idles all-ones and fills with ones, so TxD needs no idle mux
  assign TxD     = tx_shift_q[0];
  assign tx_load = wr_dr & ctrl_q[1] & ~tx_busy_q;
  assign tx_tick = tx_cnt_q == tx_cpb_q - 16'd1;
  always_comb begin
    tx_busy_d  = tx_load | (tx_busy_q & ~(tx_tick & (tx_bit_q == 4'd9)));
    tx_shift_d = tx_load ? {1'b1, din[7:0], 1'b0} : (tx_busy_q & tx_tick) ? {1'b1, tx_shift_q[9:1]} : tx_shift_q;
    tx_cnt_d   = (tx_load | ~tx_busy_q | tx_tick) ? 16'd0 : tx_cnt_q + 16'd1;
    tx_bit_d   = tx_load ? 4'd0 : (tx_busy_q & tx_tick) ? tx_bit_q + 4'd1 : tx_bit_q;
    tx_cpb_d   = tx_load ? cpb_eff : tx_cpb_q;
  end
  // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detection
  assign rx_sync_d = {rx_sync_q[1:0], RxD};
  assign rx_in     = rx_sync_q[1];
  assign rx_fall   = rx_sync_q[2] & ~rx_sync_q[1];
  assign rx_tick   = rx_cnt_q == rx_cpb_q - 16'd1;
  // two clocks of the half-bit wait are spent in the synchronizer and edge detector
  assign rx_half   = (rx_cpb_q >> 1) - 16'd2;
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_cpb_d   = rx_cpb_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cpb_d   = cpb_eff;
        end
      end
      RX_START: if (rx_cnt_q == rx_half) begin
        rx_cnt_d   = 16'd0;
        rx_bit_d   = 3'd0;
        rx_state_d = rx_in ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_d   = 16'd0;
        rx_shift_d = {rx_in, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      default: if (rx_tick) begin
        rx_cnt_d   = 16'd0;
        rx_done    = 1'b1;
        rx_state_d = RX_IDLE;
      end
    endcase
    if (!ctrl_q[0]) begin
      rx_state_d = RX_IDLE;
      rx_done    = 1'b0;
    end
  end
  // a DR read on the completion edge frees the buffer for the new byte
  assign rx_store = rx_done & (~rxfull_q | rd_dr);
  always_comb begin
    ctrl_d    = wr_ctrl ? ctrl_wdata : ctrl_q;
    cpb_d     = wr_cpb ? din[15:0] : cpb_q;
    rx_data_d = rx_store ? rx_shift_q : rx_data_q;
    rxfull_d  = rx_store | (rxfull_q & ~rd_dr);
    overrun_d = (rx_done & ~rx_store) | (overrun_q & ~(wr_stat & din[2]));
    ferr_d    = (rx_store & ~rx_in) | (ferr_q & ~(wr_stat & din[3]));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= 4'd0;
      cpb_q      <= DEFAULT_CPB;
      rxfull_q   <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data_q  <= 8'd0;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= 10'h3FF;
      tx_cnt_q   <= 16'd0;
      tx_cpb_q   <= 16'd4;
      tx_bit_q   <= 4'd0;
      rx_sync_q  <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_cpb_q   <= 16'd4;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      cpb_q      <= cpb_d;
      rxfull_q   <= rxfull_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
      rx_data_q  <= rx_data_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_cpb_q   <= tx_cpb_d;
      tx_bit_q   <= tx_bit_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_cpb_q   <= rx_cpb_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end
`ifdef UART_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = (rxfull_q & ctrl_q[2]) | (~tx_busy_q & ctrl_q[3] & ctrl_q[1]);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart.sv
// tb_uart: self-checking bench for uart (register table, TX framing, loopback, RX model, irq, async reset)
module tb_uart;
`ifdef UART_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0, wen = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        rxd_drv = 1'b1, loop = 1'b0;
  logic        txd, irq, rxd;
  int          tests = 0, fails = 0;
  logic        m_full = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0]  m_data = 8'd0;
  vec_t        rv[7];
  vec_t        wv[8];
  assign rxd = loop ? txd : rxd_drv;
  uart #(.SIM_PRINT(0), .DEFAULT_CPB(16'd100)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .RxD(rxd), .TxD(txd), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1; wen = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; wen = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    cs = 1'b1; wen = 1'b0; addr = a;
    #1 d = dout;
    @(negedge clk);
    cs = 1'b0;
  endtask
  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    cs = 1'b1; wen = 1'b0; addr = a;
    #1 d = dout;
    cs = 1'b0;
  endtask
  task automatic wait_stat(input int b, input logic v, input int lim, output logic ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      peek(4'd2, s);
      if (s[b] == v) ok = 1'b1;
      else @(negedge clk);
    end
  endtask
  task automatic reset_regs;
    logic [31:0] d;
    for (int i = 0; i < 7; i++) begin
      peek(rv[i].a, d);
      chk($sformatf("reset_reg%0d", rv[i].a), d, rv[i].e);
    end
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop, input int cpb);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (cpb) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (cpb) @(negedge clk);
  endtask
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int cpb);
    logic [31:0] s;
    send_rx(b, stop, cpb);
    if (!m_full) begin
      m_full = 1'b1;
      m_data = b;
      if (!stop) m_ferr = 1'b1;
    end else m_ovr = 1'b1;
    peek(4'd2, s);
    chk("rx_stat", s, {28'd0, m_ferr, m_ovr, 1'b0, m_full});
  endtask
  task automatic rx_read;
    logic [31:0] d;
    rd(4'd0, d);
    chk("rx_dr", d, {24'd0, m_data});
    m_full = 1'b0;
  endtask
  task automatic clr_flags(input logic [31:0] m);
    logic [31:0] s;
    wr(4'd2, m);
    if (m[2]) m_ovr = 1'b0;
    if (m[3]) m_ferr = 1'b0;
    peek(4'd2, s);
    chk("stat_clear", s, {28'd0, m_ferr, m_ovr, 1'b0, m_full});
  endtask
  initial begin
    logic [31:0] s, d;
    logic [9:0]  tf;
    logic        ok;
    int          bc, c, ce, b;
    rv[0] = '{4'd0, 32'd0, 32'd0};
    rv[1] = '{4'd1, 32'd0, 32'd0};
    rv[2] = '{4'd2, 32'd0, 32'd0};
    rv[3] = '{4'd3, 32'd0, 32'd100};
    rv[4] = '{4'd4, 32'd0, 32'd0};
    rv[5] = '{4'd9, 32'd0, 32'd0};
    rv[6] = '{4'd15, 32'd0, 32'd0};
    wv[0] = '{4'd1, 32'hF, IRQ ? 32'hF : 32'h3};
    wv[1] = '{4'd1, 32'hFFFF_FFF0, 32'h0};
    wv[2] = '{4'd3, 32'h0001_2345, 32'h2345};
    wv[3] = '{4'd3, 32'd100, 32'd100};
    wv[4] = '{4'd2, 32'hF, 32'h0};
    wv[5] = '{4'd5, 32'hFF, 32'h0};
    wv[6] = '{4'd15, 32'hFFFF_FFFF, 32'h0};
    wv[7] = '{4'd0, 32'h11, 32'h0};
    #2 reset_regs();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wr(wv[i].a, wv[i].d);
      rd(wv[i].a, d);
      chk($sformatf("regrw%0d", i), d, wv[i].e);
    end
    peek(4'd2, s);
    chk("dr_write_tx_disabled", s, 32'd0);
    wr(4'd1, 32'd3); wr(4'd3, 32'd100);
    tf = {1'b1, 8'h6D, 1'b0};
    wr(4'd0, 32'h6D);
    bc = 0;
    for (int n = 1; n <= 1100; n++) begin
      cs = 1'b1; wen = 1'b0; addr = 4'd2;
      #1 s = dout;
      if (s[1]) bc++;
      if (n % 100 == 50 && n < 1000) chk($sformatf("tx_bit%0d", n / 100), {31'd0, txd}, {31'd0, tf[n / 100]});
      if (n == 1050) chk("tx_idle", {31'd0, txd}, 32'd1);
      if (n == 10) begin wen = 1'b1; addr = 4'd0; din = 32'hFF; end
      else if (n == 20) begin wen = 1'b1; addr = 4'd3; din = 32'd50; end
      else cs = 1'b0;
      @(negedge clk);
    end
    cs = 1'b0; wen = 1'b0;
    chk("tx_busy_len", bc, 32'd1000);
    wr(4'd3, 32'd1);
    wr(4'd0, 32'hA5);
    bc = 0;
    for (int n = 1; n <= 60; n++) begin
      cs = 1'b1; wen = 1'b0; addr = 4'd2;
      #1 s = dout;
      if (s[1]) bc++;
      if (n == 5) begin wen = 1'b1; addr = 4'd1; din = 32'd1; end
      else cs = 1'b0;
      @(negedge clk);
    end
    cs = 1'b0; wen = 1'b0;
    chk("tx_min_cpb_len", bc, 32'd40);
    wr(4'd0, 32'h33);
    peek(4'd2, s);
    chk("tx_dropped_busy", {31'd0, s[1]}, 32'd0);
    loop = 1'b1;
    wr(4'd1, 32'd3);
    for (int i = 0; i < 9; i++) begin
      b  = (i == 0) ? 8'h20 : (i == 1) ? 8'h30 : (i == 2) ? 8'h0A : int'($urandom_range(0, 255));
      c  = (i < 3) ? 100 : int'($urandom_range(1, 12));
      ce = (c < 4) ? 4 : c;
      wr(4'd3, c);
      wr(4'd0, b);
      wait_stat(0, 1'b1, 12 * ce + 40, ok);
      chk("lb_wait_rxfull", {31'd0, ok}, 32'd1);
      rd(4'd0, d);
      chk($sformatf("lb_dr%0d", i), d, b);
      wait_stat(1, 1'b0, 4 * ce + 40, ok);
      chk("lb_wait_txdone", {31'd0, ok}, 32'd1);
    end
    peek(4'd2, s);
    chk("lb_flags", s, 32'd0);
    loop = 1'b0;
    wr(4'd1, 32'd1);
    wr(4'd3, 32'd8);
    rx_frame(8'h67, 1'b1, 8);
    rx_frame(8'h31, 1'b1, 8);
    rx_read();
    clr_flags(32'd4);
    rx_frame(8'h55, 1'b0, 8);
    rx_read();
    clr_flags(32'd8);
    for (int i = 0; i < 14; i++) begin
      c  = int'($urandom_range(1, 12));
      ce = (c < 4) ? 4 : c;
      wr(4'd3, c);
      rx_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), ce);
      if ($urandom_range(0, 1) == 1) rx_read();
      if ($urandom_range(0, 3) == 0) clr_flags(32'($urandom_range(0, 3)) << 2);
    end
    rx_read();
    clr_flags(32'd12);
    wr(4'd3, 32'd8);
    rxd_drv = 1'b0; repeat (8) @(negedge clk);
    rxd_drv = 1'b1; repeat (16) @(negedge clk);
    wr(4'd1, 32'd0);
    wr(4'd1, 32'd1);
    repeat (120) @(negedge clk);
    peek(4'd2, s);
    chk("rx_abort", s, 32'd0);
    wr(4'd1, 32'd0);
    send_rx(8'h5A, 1'b1, 8);
    peek(4'd2, s);
    chk("rx_disabled", s, 32'd0);
    wr(4'd1, 32'd1);
    rx_frame(8'h3C, 1'b1, 8);
    rx_read();
    wr(4'd1, 32'd5);
    peek(4'd1, d);
    chk("ctrl_ie_bits", d, IRQ ? 32'd5 : 32'd1);
    fork
      send_rx(8'h41, 1'b1, 8);
    join_none
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      peek(4'd2, s);
      if (s[0]) begin
        ok = 1'b1;
        chk("irq_before", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_rise", {31'd0, irq}, {31'd0, IRQ});
      end else @(negedge clk);
    end
    chk("irq_wait_rxfull", {31'd0, ok}, 32'd1);
    wait fork;
    rd(4'd0, d);
    chk("irq_dr", d, 32'h41);
    @(negedge clk);
    chk("irq_drop", {31'd0, irq}, 32'd0);
    wr(4'd1, 32'd3); wr(4'd3, 32'd8);
    wr(4'd0, 32'h00);
    repeat (20) @(negedge clk);
    chk("tx_mid_low", {31'd0, txd}, 32'd0);
    #2 reset = 1'b0;
    #1 reset_regs();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    peek(4'd2, s);
    chk("post_reset_stat", s, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
